// File: rtl/tdm_demux_1to8.sv
// Purpose : receive end of the 8:1 TDM lane; locates slot 0 via fsync and
//           rebuilds an 8-channel parallel word, presented atomically.
// Latency : dout/frame_valid visible the cycle after the slot-7 sample is
//           accepted; sync_err the cycle after the offending sample.
// Backpr. : none; one sample accepted per din_valid cycle, gaps allowed.
//
// Ports:
//   clk, rst_n          single clock, async active-low reset
//   din[WIDTH]          serial sample, qualified by din_valid
//   fsync               marks din as slot 0 (ignored when din_valid=0)
//   dout[8*WIDTH]       last complete frame, channel k at dout[k*WIDTH +: WIDTH]
//   frame_valid         one-cycle strobe, dout just updated
//   slot[3]             slot index the next accepted sample will fill
//   locked              high while framing is established
//   sync_err            one-cycle strobe, framing violation seen
module tdm_demux_1to8 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               fsync,
  output logic [8*WIDTH-1:0] dout,
  output logic               frame_valid,
  output logic [2:0]         slot,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  // Slots 0..6 held here; slot 7 goes straight from din into dout.
  logic [7*WIDTH-1:0]   shadow_q, shadow_d;
  logic [8*WIDTH-1:0]   dout_q, dout_d;
  logic                 fv_q, fv_d;
  logic                 se_q, se_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (fsync) begin
            shadow_d[0 +: WIDTH] = din;
            cnt_d                = 3'd1;
            state_d              = RUN;
          end
        end
        RUN: begin
          if (fsync) begin
            // A marker anywhere but slot 0 restarts the frame in place;
            // stale slots 1..6 get overwritten before the next completion.
            se_d                 = (cnt_q != 3'd0);
            shadow_d[0 +: WIDTH] = din;
            cnt_d                = 3'd1;
          end else if (cnt_q == 3'd0) begin
            se_d    = 1'b1;
            state_d = HUNT;
            cnt_d   = 3'd0;
          end else if (cnt_q == 3'd7) begin
            dout_d = {din, shadow_q};
            fv_d   = 1'b1;
            cnt_d  = 3'd0;
          end else begin
            for (int k = 1; k < 7; k++) begin
              if (cnt_q == 3'(k)) shadow_d[k*WIDTH +: WIDTH] = din;
            end
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign slot        = cnt_q;
  assign locked      = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux_1to8.sv
module tb_tdm_demux_1to8;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          fsync = 1'b0;
  logic [8*W-1:0] dout;
  logic          frame_valid;
  logic [2:0]    slot;
  logic          locked;
  logic          sync_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: frame under construction kept as a queue of samples since the
  // last marker; the expected slot is simply how many samples it holds.
  logic [W-1:0]   mq[$];
  bit             m_locked = 1'b0;
  logic [8*W-1:0] m_dout = '0;
  bit             m_fv = 1'b0;
  bit             m_se = 1'b0;

  tdm_demux_1to8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .fsync(fsync), .dout(dout), .frame_valid(frame_valid), .slot(slot),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_locked = 1'b0;
    m_dout   = '0;
    m_fv     = 1'b0;
    m_se     = 1'b0;
  endtask

  task automatic model_step();
    m_fv = 1'b0;
    m_se = 1'b0;
    if (din_valid) begin
      if (fsync) begin
        if (m_locked && mq.size() != 0) m_se = 1'b1;
        mq.delete();
        mq.push_back(din);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (mq.size() == 0) begin
          m_se     = 1'b1;
          m_locked = 1'b0;
        end else begin
          mq.push_back(din);
          if (mq.size() == 8) begin
            for (int k = 0; k < 8; k++) m_dout[k*W +: W] = mq[k];
            m_fv = 1'b1;
            mq.delete();
          end
        end
      end
    end
  endtask

  // One clock: model consumes exactly what the DUT samples on this edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic f);
    din       = d;
    fsync     = f;
    din_valid = 1'b1;
    cycle();
    din_valid = 1'b0;
    fsync     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_dout", dout, m_dout);
        chk("cyc_frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("cyc_sync_err", 32'(sync_err), 32'(m_se));
        chk("cyc_slot", 32'(slot), 32'(mq.size()));
        chk("cyc_locked", 32'(locked), 32'(m_locked));
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_se", 32'(sync_err), 32'h0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    idle(1);

    // Clean frame 0..7
    send(4'h0, 1'b1);
    for (int i = 1; i < 8; i++) send(4'(i), 1'b0);
    chk("f1_model_dout", m_dout, 32'h76543210);
    chk("f1_dout", dout, 32'h76543210);
    chk("f1_fv", 32'(frame_valid), 32'h1);
    chk("f1_locked", 32'(locked), 32'h1);
    chk("f1_slot", 32'(slot), 32'h0);
    idle(1);
    chk("f1_fv_drop", 32'(frame_valid), 32'h0);

    // Missing marker at slot 0
    send(4'h3, 1'b0);
    chk("miss_se", 32'(sync_err), 32'h1);
    chk("miss_locked", 32'(locked), 32'h0);
    chk("miss_dout_held", dout, 32'h76543210);
    idle(2);

    // Hunting: unmarked samples dropped, then frame with marker on 0xA
    send(4'h5, 1'b0);
    chk("hunt1_locked", 32'(locked), 32'h0);
    send(4'h6, 1'b0);
    chk("hunt2_locked", 32'(locked), 32'h0);
    chk("hunt2_se", 32'(sync_err), 32'h0);
    send(4'hA, 1'b1);
    chk("hunt_lock", 32'(locked), 32'h1);
    for (int i = 1; i < 8; i++) send(4'(i), 1'b0);
    chk("f2_model_dout", m_dout, 32'h7654321A);
    chk("f2_dout", dout, 32'h7654321A);
    chk("f2_fv", 32'(frame_valid), 32'h1);

    // Gap of 3 idle cycles after slot 3
    for (int i = 0; i < 4; i++) send(4'(i), i == 0);
    idle(3);
    chk("gap_slot", 32'(slot), 32'h4);
    chk("gap_fv", 32'(frame_valid), 32'h0);
    for (int i = 4; i < 8; i++) send(4'(i), 1'b0);
    chk("f3_dout", dout, 32'h76543210);
    chk("f3_fv", 32'(frame_valid), 32'h1);

    // Early marker at slot 5 carrying 0x9
    for (int i = 0; i < 5; i++) send(4'(i), i == 0);
    send(4'h9, 1'b1);
    chk("early_se", 32'(sync_err), 32'h1);
    chk("early_fv", 32'(frame_valid), 32'h0);
    chk("early_slot", 32'(slot), 32'h1);
    chk("early_locked", 32'(locked), 32'h1);
    for (int i = 1; i < 8; i++) send(4'(i), 1'b0);
    chk("f4_model_dout", m_dout, 32'h76543219);
    chk("f4_dout", dout, 32'h76543219);
    chk("f4_fv", 32'(frame_valid), 32'h1);

    // Reset mid-frame, then a clean frame 8..F
    send(4'hC, 1'b1);
    for (int i = 1; i < 4; i++) send(4'(i), 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_dout", dout, 32'h0);
    chk("mrst_locked", 32'(locked), 32'h0);
    chk("mrst_slot", 32'(slot), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 8; i < 16; i++) send(4'(i), i == 8);
    chk("f5_dout", dout, 32'hFEDCBA98);
    chk("f5_fv", 32'(frame_valid), 32'h1);
    idle(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to8.md
# tdm_demux_1to8

Time-division 1:8 demultiplexer: the receive end of the 8:1 select-driven serial link built from our mux blocks. It takes one sample per valid cycle from a shared serial lane, uses a frame-sync marker to locate slot 0, and rebuilds a registered 8-channel parallel word. Each complete frame is presented atomically with a one-cycle strobe. It sits between the serial lane and the per-channel consumers.

## Interface
- WIDTH, 1, bits per sample (per channel)
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  serial sample from the lane
- din_valid  input  1  din is a sample this cycle
- fsync  input  1  marks the din sample as slot 0; qualified by din_valid
- dout  output  8*WIDTH  last complete frame; channel k at dout[k*WIDTH +: WIDTH]
- frame_valid  output  1  one-cycle strobe: dout just updated
- slot  output  3  slot index the next accepted sample will fill
- locked  output  1  high in RUN state
- sync_err  output  1  one-cycle strobe: framing violation detected

## Operation
- Slot k maps to channel k. Select 000 = channel 0, matching the transmit-side mux ordering.
- Internal: 2-state FSM (HUNT, RUN), 3-bit slot counter cnt, shadow registers for slots 0..6.
- Cycles with din_valid=0 change nothing. fsync is ignored in those cycles.
- HUNT:
  - A sample without fsync is dropped.
  - A sample with fsync is written to shadow[0]; cnt<=1; go to RUN.
- RUN, accepted sample with cnt==0:
  - fsync=1: shadow[0]<=din; cnt<=1.
  - fsync=0: missing marker. Pulse sync_err, drop the sample, go to HUNT, cnt<=0.
- RUN, accepted sample with 1<=cnt<=6:
  - fsync=0: shadow[cnt]<=din; cnt<=cnt+1.
  - fsync=1: early marker. Pulse sync_err, discard the partial frame, shadow[0]<=din, cnt<=1, stay in RUN (resync in place).
- RUN, accepted sample with cnt==7:
  - fsync=0: dout<={din, shadow[6..0]}; pulse frame_valid; cnt<=0 (wraps 7 to 0).
  - fsync=1: handled as an early marker (see above). dout is not updated.
- dout changes only on frame completion and holds between frames, including across HUNT periods.
- slot = cnt; locked = (state==RUN).
- frame_valid and sync_err are never high in the same cycle.

## Timing
- All outputs are registered.
- Reset values: dout=0, frame_valid=0, sync_err=0, slot=0, locked=0, FSM=HUNT, shadow=0.
- Latency: dout and frame_valid update on the clock edge that accepts the slot-7 sample, so they are visible in the next cycle. frame_valid is high for exactly that one cycle.
- sync_err asserts on the edge that accepts the offending sample and is high for one cycle.
- Maximum throughput: one sample per cycle, one frame per 8 valid cycles. No backpressure; the block always accepts.
- Gaps (din_valid=0) of any length between samples are allowed and do not affect framing.
- Reset asserted mid-frame: the partial frame is discarded and all outputs return to reset values immediately (asynchronous). After rst_n deasserts, the block starts in HUNT.

## Test plan
- WIDTH=4. After reset, send fsync with 8 back-to-back samples 0x0..0x7 -> frame_valid for 1 cycle after the 8th sample; dout=0x76543210; locked=1; slot returns to 0.
- Send 2 samples without fsync, then a frame 0xA,0x1..0x7 with fsync on 0xA -> the first 2 samples are dropped (locked=0 until fsync); dout=0x7654321A.
- Frame with din_valid deasserted for 3 cycles after slot 3 -> same dout as the gap-free case; frame_valid timing shifts by 3 cycles.
- While locked, assert fsync on the slot-5 sample 0x9, then send 7 more samples 0x1..0x7 -> sync_err pulses once, with no frame_valid at that sample; the next frame_valid gives dout=0x76543219.
- After a good frame, send a slot-0 sample without fsync -> sync_err pulses, locked=0, and dout keeps its previous value.
- Pull rst_n low after 4 samples of a frame -> dout=0, locked=0, slot=0 immediately. A following full frame gives the correct dout with no stale slots.
